// File: rtl/m2_block_scheduler.sv
// Milestone 2 block sequencer: runs FS/CT/CS/WS in a two-deep software-pipelined
// order over every 8x8 block of the Y, U and V planes.
module m2_block_scheduler #(
  parameter int Y_COLS  = 40,
  parameter int UV_COLS = 20,
  parameter int ROWS    = 30
) (
  input  logic       CLOCK_50_I,
  input  logic       Reset,
  input  logic       M2_start,
  output logic       M2_done,
  output logic       busy,
  output logic       FS_start,
  output logic       CT_start,
  output logic       CS_start,
  output logic       WS_start,
  input  logic       FS_done,
  input  logic       CT_done,
  input  logic       CS_done,
  input  logic       WS_done,
  output logic [1:0] fs_plane,
  output logic [1:0] ws_plane,
  output logic [4:0] fs_row,
  output logic [4:0] ws_row,
  output logic [5:0] fs_col,
  output logic [5:0] ws_col
);

  localparam int         N        = (Y_COLS + 2 * UV_COLS) * ROWS;
  localparam logic [31:0] N_U     = 32'(N);
  localparam logic [5:0] Y_LAST   = 6'(Y_COLS - 1);
  localparam logic [5:0] UV_LAST  = (UV_COLS > 0) ? 6'(UV_COLS - 1) : 6'd0;
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, LI_FS, LI_CT, MEGA_A, MEGA_B, LO_CS, LO_WS, FIN
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] k_reg;
  logic [31:0] k_plus2;
  logic [3:0]  flag_reg;
  logic [3:0]  start_reg;
  logic [3:0]  unit_done;
  logic [3:0]  unit_act;
  logic        complete;
  logic [1:0]  adv;

  // Unit bit order everywhere: {WS, CS, CT, FS}
  function automatic logic [3:0] units_of(input state_t s);
    case (s)
      LI_FS:   return 4'b0001;
      LI_CT:   return 4'b0010;
      MEGA_A:  return 4'b0101;
      MEGA_B:  return 4'b1010;
      LO_CS:   return 4'b0100;
      LO_WS:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  assign unit_done = {WS_done, CS_done, CT_done, FS_done};
  assign unit_act  = units_of(state_reg);
  // A done arriving on the completing edge counts without waiting for its flag.
  assign complete  = (unit_act != 4'b0000) &&
                     ((unit_act & ~(flag_reg | unit_done)) == 4'b0000);
  assign k_plus2   = {16'd0, k_reg} + 32'd2;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (M2_start) state_next = LI_FS;
      LI_FS:   if (complete) state_next = LI_CT;
      LI_CT:   if (complete) state_next = (N > 1) ? MEGA_A : LO_CS;
      MEGA_A:  if (complete) state_next = MEGA_B;
      MEGA_B:  if (complete) state_next = (k_plus2 < N_U) ? MEGA_A : LO_CS;
      LO_CS:   if (complete) state_next = LO_WS;
      LO_WS:   if (complete) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_reg <= IDLE;
      start_reg <= 4'b0000;
      flag_reg  <= 4'b0000;
      k_reg     <= 16'd0;
      busy      <= 1'b0;
      M2_done   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != IDLE);
      M2_done   <= (state_next == FIN);
      if (state_next != state_reg) begin
        start_reg <= units_of(state_next);
        flag_reg  <= 4'b0000;
      end else begin
        start_reg <= 4'b0000;
        flag_reg  <= flag_reg | (unit_done & unit_act);
      end
      if (state_reg == IDLE && M2_start)
        k_reg <= 16'd0;
      else if (state_reg == MEGA_B && complete)
        k_reg <= k_reg + 16'd1;
    end
  end

  assign {WS_start, CS_start, CT_start, FS_start} = start_reg;

  // Index 0 walks the FS block order, index 1 the WS block order.
  assign adv[0] = complete & unit_act[0];
  assign adv[1] = complete & unit_act[3];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_coord
      logic [1:0] plane_reg;
      logic [4:0] row_reg;
      logic [5:0] col_reg;
      logic [5:0] last_col;

      assign last_col = (plane_reg == 2'd0) ? Y_LAST : UV_LAST;

      always_ff @(posedge CLOCK_50_I) begin
        if (Reset || (state_reg == IDLE && M2_start)) begin
          plane_reg <= 2'd0;
          row_reg   <= 5'd0;
          col_reg   <= 6'd0;
        end else if (adv[gi]) begin
          if (col_reg == last_col) begin
            col_reg <= 6'd0;
            if (row_reg == ROW_LAST) begin
              row_reg   <= 5'd0;
              plane_reg <= (plane_reg == 2'd2) ? 2'd0 : plane_reg + 2'd1;
            end else begin
              row_reg <= row_reg + 5'd1;
            end
          end else begin
            col_reg <= col_reg + 6'd1;
          end
        end
      end
    end
  endgenerate

  assign fs_plane = g_coord[0].plane_reg;
  assign fs_row   = g_coord[0].row_reg;
  assign fs_col   = g_coord[0].col_reg;
  assign ws_plane = g_coord[1].plane_reg;
  assign ws_row   = g_coord[1].row_reg;
  assign ws_col   = g_coord[1].col_reg;

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: a full default-size run with an auto-responder,
// table-driven phase vectors on N=4 and N=1 instances, and a mid-run reset.
module tb_m2_block_scheduler;

  localparam logic [3:0] FS = 4'b0001;
  localparam logic [3:0] CT = 4'b0010;
  localparam logic [3:0] CS = 4'b0100;
  localparam logic [3:0] WS = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      m2s;
  logic [2:0][3:0] dn;
  logic [2:0][3:0] st;
  logic [2:0]      m2d;
  logic [2:0]      bsy;
  logic [2:0][1:0] fp, wp;
  logic [2:0][4:0] fr, wr;
  logic [2:0][5:0] fc, wc;

  int checks = 0;
  int errors = 0;

  m2_block_scheduler u0 (
    .CLOCK_50_I(clk), .Reset(rst), .M2_start(m2s[0]), .M2_done(m2d[0]), .busy(bsy[0]),
    .FS_start(st[0][0]), .CT_start(st[0][1]), .CS_start(st[0][2]), .WS_start(st[0][3]),
    .FS_done(dn[0][0]), .CT_done(dn[0][1]), .CS_done(dn[0][2]), .WS_done(dn[0][3]),
    .fs_plane(fp[0]), .ws_plane(wp[0]), .fs_row(fr[0]), .ws_row(wr[0]),
    .fs_col(fc[0]), .ws_col(wc[0])
  );

  m2_block_scheduler #(.Y_COLS(2), .UV_COLS(1), .ROWS(1)) u1 (
    .CLOCK_50_I(clk), .Reset(rst), .M2_start(m2s[1]), .M2_done(m2d[1]), .busy(bsy[1]),
    .FS_start(st[1][0]), .CT_start(st[1][1]), .CS_start(st[1][2]), .WS_start(st[1][3]),
    .FS_done(dn[1][0]), .CT_done(dn[1][1]), .CS_done(dn[1][2]), .WS_done(dn[1][3]),
    .fs_plane(fp[1]), .ws_plane(wp[1]), .fs_row(fr[1]), .ws_row(wr[1]),
    .fs_col(fc[1]), .ws_col(wc[1])
  );

  m2_block_scheduler #(.Y_COLS(1), .UV_COLS(0), .ROWS(1)) u2 (
    .CLOCK_50_I(clk), .Reset(rst), .M2_start(m2s[2]), .M2_done(m2d[2]), .busy(bsy[2]),
    .FS_start(st[2][0]), .CT_start(st[2][1]), .CS_start(st[2][2]), .WS_start(st[2][3]),
    .FS_done(dn[2][0]), .CT_done(dn[2][1]), .CS_done(dn[2][2]), .WS_done(dn[2][3]),
    .fs_plane(fp[2]), .ws_plane(wp[2]), .fs_row(fr[2]), .ws_row(wr[2]),
    .fs_col(fc[2]), .ws_col(wc[2])
  );

  typedef struct {
    int         inst;
    bit         kick;   // pulse M2_start before this phase
    logic [3:0] mask;   // expected start pulses on phase entry
    logic [3:0] da;
    int         ta;
    logic [3:0] db;
    int         tb;
    logic [3:0] xd;     // done pulses for units not in the phase
    bit         xs;     // M2_start while running
    int         tx;
    bit         cc;     // check coordinates
    logic [12:0] efs;
    logic [12:0] ews;
    bit         fin;
  } vec_t;

  function automatic logic [12:0] co(input int p, input int r, input int c);
    return {2'(p), 5'(r), 6'(c)};
  endfunction

  function automatic logic [12:0] fsc(input int i);
    return {fp[i], fr[i], fc[i]};
  endfunction

  function automatic logic [12:0] wsc(input int i);
    return {wp[i], wr[i], wc[i]};
  endfunction

  function automatic vec_t mk(input int inst, input bit kick, input logic [3:0] mask,
                              input logic [3:0] da, input int ta, input logic [3:0] db,
                              input int tb, input logic [3:0] xd, input bit xs, input int tx,
                              input bit cc, input logic [12:0] efs, input logic [12:0] ews,
                              input bit fin);
    vec_t v;
    v.inst = inst; v.kick = kick; v.mask = mask; v.da = da; v.ta = ta; v.db = db; v.tb = tb;
    v.xd = xd; v.xs = xs; v.tx = tx; v.cc = cc; v.efs = efs; v.ews = ews; v.fin = fin;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one scheduler phase: checks entry, drives dones at their offsets,
  // and requires silence on the start lines until the last done is in.
  task automatic run_vec(input int r, input vec_t v);
    int i;
    int tl;
    i = v.inst;
    if (v.kick) begin
      m2s[i] = 1'b1;
      @(negedge clk);
      m2s[i] = 1'b0;
    end
    $display("vec %0d inst %0d start=%b fs=%h ws=%h busy=%b", r, i, st[i], fsc(i), wsc(i), bsy[i]);
    chk($sformatf("v%0d_start", r), 32'(st[i]), 32'(v.mask));
    chk($sformatf("v%0d_busy", r), 32'(bsy[i]), 32'd1);
    if (v.cc) begin
      chk($sformatf("v%0d_fs", r), 32'(fsc(i)), 32'(v.efs));
      chk($sformatf("v%0d_ws", r), 32'(wsc(i)), 32'(v.ews));
    end
    tl = v.ta;
    if (v.tb > tl) tl = v.tb;
    if (v.tx > tl) tl = v.tx;
    for (int t = 0; t <= tl; t++) begin
      if (t > 0) begin
        @(negedge clk);
        dn[i] = 4'b0000;
        m2s[i] = 1'b0;
        chk($sformatf("v%0d_quiet_t%0d", r, t), 32'(st[i]), 32'd0);
      end
      if (t == v.ta) dn[i] = dn[i] | v.da;
      if (t == v.tb) dn[i] = dn[i] | v.db;
      if (t == v.tx) begin
        dn[i] = dn[i] | v.xd;
        m2s[i] = m2s[i] | v.xs;
      end
    end
    @(negedge clk);
    dn[i] = 4'b0000;
    m2s[i] = 1'b0;
    if (v.fin) begin
      chk($sformatf("v%0d_m2done", r), 32'(m2d[i]), 32'd1);
      chk($sformatf("v%0d_fin_busy", r), 32'(bsy[i]), 32'd1);
      chk($sformatf("v%0d_fin_start", r), 32'(st[i]), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_m2done_off", r), 32'(m2d[i]), 32'd0);
      chk($sformatf("v%0d_idle_busy", r), 32'(bsy[i]), 32'd0);
      if (v.cc) begin
        chk($sformatf("v%0d_fs_wrap", r), 32'(fsc(i)), 32'd0);
        chk($sformatf("v%0d_ws_wrap", r), 32'(wsc(i)), 32'd0);
      end
    end
  endtask

  vec_t tbl[14];
  logic [12:0] b0, b1, b2, b3;
  int nst[4];
  int cnt[4];
  int ndone;
  int cyc;
  int tail;

  initial begin
    b0 = co(0, 0, 0); b1 = co(0, 0, 1); b2 = co(1, 0, 0); b3 = co(2, 0, 0);
    // N=4: coordinates b0..b3; fs leads ws by one block
    tbl[0]  = mk(1, 1, FS,      FS,      2, 4'b0, 0, 4'b0, 0, 0, 1, b0, b0, 0);
    tbl[1]  = mk(1, 0, CT,      CT,      0, 4'b0, 0, 4'b0, 0, 0, 1, b1, b0, 0);
    tbl[2]  = mk(1, 0, CS | FS, CS,      5, FS,   9, WS,   0, 3, 1, b1, b0, 0);
    tbl[3]  = mk(1, 0, CT | WS, CT | WS, 1, 4'b0, 0, 4'b0, 1, 0, 1, b2, b0, 0);
    tbl[4]  = mk(1, 0, CS | FS, FS,      5, CS,   9, 4'b0, 0, 0, 1, b2, b1, 0);
    tbl[5]  = mk(1, 0, CT | WS, CT | WS, 0, 4'b0, 0, 4'b0, 0, 0, 1, b3, b1, 0);
    tbl[6]  = mk(1, 0, CS | FS, CS | FS, 2, 4'b0, 0, 4'b0, 0, 0, 1, b3, b2, 0);
    tbl[7]  = mk(1, 0, CT | WS, WS,      1, CT,   3, 4'b0, 0, 0, 1, b0, b2, 0);
    tbl[8]  = mk(1, 0, CS,      CS,      1, 4'b0, 0, 4'b0, 0, 0, 1, b0, b3, 0);
    tbl[9]  = mk(1, 0, WS,      WS,      0, 4'b0, 0, 4'b0, 0, 0, 1, b0, b3, 1);
    // N=1: straight from the lead-in to the lead-out
    tbl[10] = mk(2, 1, FS,      FS,      3, 4'b0, 0, 4'b0, 0, 0, 1, b0, b0, 0);
    tbl[11] = mk(2, 0, CT,      CT,      1, 4'b0, 0, 4'b0, 0, 0, 0, b0, b0, 0);
    tbl[12] = mk(2, 0, CS,      CS,      0, 4'b0, 0, 4'b0, 0, 0, 0, b0, b0, 0);
    tbl[13] = mk(2, 0, WS,      WS,      2, 4'b0, 0, 4'b0, 0, 0, 0, b0, b0, 1);

    rst = 1'b1;
    m2s = '0;
    dn  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      $display("reset inst %0d start=%b busy=%b done=%b", i, st[i], bsy[i], m2d[i]);
      chk($sformatf("rst%0d_start", i), 32'(st[i]), 32'd0);
      chk($sformatf("rst%0d_busy", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("rst%0d_m2done", i), 32'(m2d[i]), 32'd0);
      chk($sformatf("rst%0d_coords", i), 32'({fsc(i), wsc(i)}), 32'd0);
    end

    // Full default run, every done returned 3 cycles after its start
    chk("full_start_before", 32'(st[0]), 32'd0);
    m2s[0] = 1'b1;
    @(negedge clk);
    m2s[0] = 1'b0;
    chk("full_fs_first", 32'(st[0]), 32'(FS));
    chk("full_busy", 32'(bsy[0]), 32'd1);
    for (int u = 0; u < 4; u++) begin
      nst[u] = 0;
      cnt[u] = 0;
    end
    ndone = 0;
    cyc = 0;
    tail = -1;
    while (cyc < 30000 && tail != 0) begin
      for (int u = 0; u < 4; u++) begin
        dn[0][u] = 1'b0;
        if (cnt[u] > 0) begin
          cnt[u]--;
          if (cnt[u] == 0) dn[0][u] = 1'b1;
        end
        if (st[0][u]) begin
          nst[u]++;
          cnt[u] = 3;
        end
      end
      if (m2d[0]) begin
        ndone++;
        tail = 5;
      end else if (tail > 0) begin
        tail--;
      end
      @(negedge clk);
      cyc++;
    end
    dn[0] = 4'b0000;
    $display("full run cycles=%0d fs=%0d ct=%0d cs=%0d ws=%0d m2done=%0d",
             cyc, nst[0], nst[1], nst[2], nst[3], ndone);
    chk("full_timeout", 32'(cyc < 30000), 32'd1);
    chk("full_fs_count", 32'(nst[0]), 32'd2400);
    chk("full_ct_count", 32'(nst[1]), 32'd2400);
    chk("full_cs_count", 32'(nst[2]), 32'd2400);
    chk("full_ws_count", 32'(nst[3]), 32'd2400);
    chk("full_m2done_count", 32'(ndone), 32'd1);
    chk("full_busy_after", 32'(bsy[0]), 32'd0);
    chk("full_coords_wrap", 32'({fsc(0), wsc(0)}), 32'd0);

    for (int r = 0; r < 14; r++) run_vec(r, tbl[r]);

    // Reset in MEGA_B, then a stale CT_done that must not restart anything
    m2s[1] = 1'b1;
    @(negedge clk);
    m2s[1] = 1'b0;
    chk("rstmid_fs", 32'(st[1]), 32'(FS));
    dn[1] = FS;
    @(negedge clk);
    dn[1] = CT;
    chk("rstmid_ct", 32'(st[1]), 32'(CT));
    @(negedge clk);
    dn[1] = CS | FS;
    chk("rstmid_a", 32'(st[1]), 32'(CS | FS));
    @(negedge clk);
    dn[1] = 4'b0000;
    chk("rstmid_b", 32'(st[1]), 32'(CT | WS));
    chk("rstmid_fs_pre", 32'(fsc(1)), 32'(b2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset in MEGA_B start=%b busy=%b done=%b fs=%h", st[1], bsy[1], m2d[1], fsc(1));
    chk("rstmid_start", 32'(st[1]), 32'd0);
    chk("rstmid_busy", 32'(bsy[1]), 32'd0);
    chk("rstmid_coords", 32'({fsc(1), wsc(1)}), 32'd0);
    dn[1] = CT;
    @(negedge clk);
    dn[1] = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("rstmid_idle_t%0d", t), 32'({st[1], bsy[1], m2d[1]}), 32'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m2_block_scheduler.md
Name: m2_block_scheduler

Overview:
- Top-level sequencer for Milestone 2 (IDCT) processing of 8x8 blocks.
- Issues start pulses to the Fetch S' (FS), Compute T (CT), Compute S (CS) and Write S (WS) units and collects their done pulses.
- Overlaps FS with CS, and CT with WS, so that each DPRAM is touched by at most two units at a time.
- Supplies the FS and WS units with independent block coordinates (plane, row, column) walking Y, then U, then V.

Parameters:
Y_COLS, 40, 8x8 block columns in the Y plane (320/8)
UV_COLS, 20, 8x8 block columns in each of the U and V planes
ROWS, 30, 8x8 block rows per plane (240/8)

Ports:
CLOCK_50_I  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
M2_start  in  1  1-cycle pulse; honoured only in IDLE
M2_done  out  1  1-cycle pulse when the last WS completes
busy  out  1  high in every state except IDLE
FS_start, CT_start, CS_start, WS_start  out  1 each  1-cycle start pulses
FS_done, CT_done, CS_done, WS_done  in  1 each  1-cycle done pulses from the units
fs_plane, ws_plane  out  2 each  0=Y, 1=U, 2=V
fs_row, ws_row  out  5 each  block row, 0..ROWS-1
fs_col, ws_col  out  6 each  block column, 0..Y_COLS-1 or 0..UV_COLS-1

Behaviour:
- Reset (checked before any other condition) forces:
  - state = IDLE;
  - all start pulses, M2_done and busy = 0;
  - all coordinates = 0;
  - all done flags cleared.
- Reset mid-operation aborts immediately. Done pulses that arrive later are ignored because IDLE ignores dones.
- N = (Y_COLS + 2*UV_COLS) * ROWS, i.e. 2400 blocks at the default parameters.
- k denotes the block currently in CT/CS.
- States and what each one runs:
  - IDLE: no units running.
  - LI_FS: FS(0).
  - LI_CT: CT(0).
  - MEGA_A: CS(k) in parallel with FS(k+1).
  - MEGA_B: CT(k+1) in parallel with WS(k).
  - LO_CS: CS(N-1).
  - LO_WS: WS(N-1).
  - FIN: no units running; M2_done is high.
- Start pulses are registered:
  - On the edge that enters a state, that state's start output(s) are set to 1.
  - They are cleared on the following edge, so each start is high for exactly one cycle.
- Done capture:
  - On state entry, the sticky flag of every unit in that state is cleared.
  - A done pulse for a unit of the current state sets its flag.
  - Done pulses for units not in the current state are ignored.
  - Two dones in the same cycle are both captured.
  - The state is complete when (flag OR incoming pulse) holds for every unit of the state. The transition then happens on that same edge: 0 extra cycles after the last done.
  - A done that coincides with the start pulse cycle is still accepted.
- Transitions:
  - IDLE -> LI_FS on M2_start.
  - LI_FS -> LI_CT on completion.
  - LI_CT -> MEGA_A if N>1, else -> LO_CS.
  - MEGA_A -> MEGA_B on completion.
  - MEGA_B -> MEGA_A if k+1 < N-1, else -> LO_CS.
  - LO_CS -> LO_WS.
  - LO_WS -> FIN.
  - FIN -> IDLE after 1 cycle.
- Coordinate counters:
  - fs_* advance by one block on the edge where a state containing FS completes.
  - ws_* advance on the edge where a state containing WS completes.
  - Outputs are stable for the whole of each unit run.
- Advance rule:
  - col+1.
  - On col = last column of the plane: col=0, row+1.
  - On row = ROWS-1: row=0, plane+1.
  - Column limit is Y_COLS-1 for plane 0 and UV_COLS-1 for planes 1 and 2.
  - After the final block (plane 2, last row, last column) the counter wraps to plane 0, row 0, col 0.
- Block-count relation: fs index = k+1 during MEGA_A; ws index = k during MEGA_B.
- Counters are cleared when IDLE sees M2_start.
- M2_start outside IDLE is ignored.
- busy=1 from the edge after M2_start through FIN.
- M2_done is high only during the FIN cycle.

Test Plan:
- Reset then defaults; M2_start; each done returned 3 cycles after its start -> FS_start high exactly 1 cycle after M2_start; exactly 2400 FS_start, CT_start, CS_start and WS_start pulses each; one M2_done; busy=0 afterwards.
- Y_COLS=2, UV_COLS=1, ROWS=1 (N=4) -> fs coordinate sequence (0,0,0), (0,0,1), (1,0,0), (2,0,0); ws sequence identical and lagging; state order LI_FS, LI_CT, A, B, A, B, A, B, LO_CS, LO_WS, FIN.
- Y_COLS=1, UV_COLS=0, ROWS=1 (N=1) -> LI_FS, LI_CT, LO_CS, LO_WS, FIN; no MEGA states; M2_done once.
- In MEGA_A, CS_done at cycle 5 and FS_done at cycle 9 -> CT_start and WS_start are issued together in cycle 10; swapping the order gives the same result; simultaneous dones give a 1-cycle advance.
- Spurious WS_done during MEGA_A, and M2_start during MEGA_B -> no state or coordinate change.
- Reset asserted in MEGA_B, then a late CT_done -> IDLE, all outputs 0, busy=0, no M2_done.
